// File: rtl/zacore_imem.sv
// zacore_imem: memory-side responder for the Zacore fetch handshake.
// Word-addressed instruction RAM with programmable wait states, a load port
// for program download and write-first forwarding on load/read collisions.
// Optional next-line prefetch is enabled by defining ZACORE_IMEM_NEXT_PREFETCH_EN.
module zacore_imem #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] ILLEGAL_WORD = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    output logic        o_fetch_ack,
    input  logic [29:0] i_fetch_addr,
    output logic [31:0] o_inst_read,
    output logic        o_fault,
    input  logic        i_load_we,
    input  logic [29:0] i_load_addr,
    input  logic [31:0] i_load_data
);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [3:0]  WS_FULL = 4'(WAIT_STATES);
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // An extra top bit keeps the compare exact when DEPTH is 2^30.
    function automatic logic in_range(input logic [29:0] a);
        in_range = ({1'b0, a} < DEPTH_W);
    endfunction

    logic [31:0] mem [DEPTH];

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [29:0] addr_r;
    logic        latch_s;
    logic        ack_r, fault_r;
    logic [31:0] inst_r;
    logic        hit_s;
    logic [29:0] rd_addr_s;
    logic        enter_resp_s;

    // With zero wait states IDLE goes straight to RESP, so the read address is the live one.
    assign rd_addr_s    = (state_r == S_IDLE) ? i_fetch_addr : addr_r;
    assign enter_resp_s = (state_s == S_RESP) && (state_r != S_RESP);

    // Next-state logic: request sampling, wait countdown and abort on dropped request.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        latch_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_fetch_req && !hit_s) begin
                    latch_s = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_s = S_RESP;
                    end else begin
                        state_s = S_WAIT;
                        cnt_s   = WS_LOAD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!i_fetch_req) begin
                    state_s = S_IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    state_s = S_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            S_RESP: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state, wait counter and latched request address.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 30'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (latch_s) begin
                addr_r <= i_fetch_addr;
            end
        end
    end

    // Registered response: ack/fault decode and read data with write-first forwarding.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_r   <= 1'b0;
            fault_r <= 1'b0;
            inst_r  <= 32'd0;
        end else begin
            ack_r   <= enter_resp_s;
            fault_r <= enter_resp_s && !in_range(rd_addr_s);
            if (enter_resp_s) begin
                if (!in_range(rd_addr_s)) begin
                    inst_r <= ILLEGAL_WORD;
                end else if (i_load_we && (i_load_addr == rd_addr_s)) begin
                    inst_r <= i_load_data;
                end else begin
                    inst_r <= mem[rd_addr_s[AW-1:0]];
                end
            end
        end
    end

    // Load port write; RAM contents survive reset, out-of-range writes are dropped.
    always_ff @(posedge i_clk) begin
        if (i_load_we && in_range(i_load_addr)) begin
            mem[i_load_addr[AW-1:0]] <= i_load_data;
        end
    end

`ifdef ZACORE_IMEM_NEXT_PREFETCH_EN
    logic        pf_active_r, pf_valid_r;
    logic [29:0] pf_addr_r;
    logic [3:0]  pf_cnt_r;
    logic [31:0] pf_buf_r;
    logic [29:0] pf_next_s;
    logic        pf_start_s;
    logic        pf_kill_s;

    assign hit_s = (state_r == S_IDLE) && i_fetch_req && pf_valid_r && (i_fetch_addr == pf_addr_r);

    // Choose the next speculative address after a normal response or a buffer hit.
    always_comb begin
        pf_next_s  = 30'd0;
        pf_start_s = 1'b0;
        if (state_r == S_RESP) begin
            pf_next_s  = addr_r + 30'd1;
            pf_start_s = in_range(pf_next_s);
        end else if (hit_s) begin
            pf_next_s  = pf_addr_r + 30'd1;
            pf_start_s = in_range(pf_next_s);
        end else begin
            pf_start_s = 1'b0;
        end
        pf_kill_s = ((state_r == S_IDLE) && i_fetch_req && !hit_s) ||
                    (i_load_we && (i_load_addr == pf_addr_r));
    end

    // Prefetch engine: countdown, buffer fill, and invalidation on miss or stale write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pf_active_r <= 1'b0;
            pf_valid_r  <= 1'b0;
            pf_addr_r   <= 30'd0;
            pf_cnt_r    <= 4'd0;
            pf_buf_r    <= 32'd0;
        end else if (pf_start_s) begin
            pf_active_r <= !(i_load_we && (i_load_addr == pf_next_s));
            pf_valid_r  <= 1'b0;
            pf_addr_r   <= pf_next_s;
            pf_cnt_r    <= WS_FULL;
        end else if (hit_s || pf_kill_s) begin
            pf_active_r <= 1'b0;
            pf_valid_r  <= 1'b0;
        end else if (pf_active_r) begin
            if (pf_cnt_r == 4'd0) begin
                pf_buf_r    <= mem[pf_addr_r[AW-1:0]];
                pf_valid_r  <= 1'b1;
                pf_active_r <= 1'b0;
            end else begin
                pf_cnt_r <= pf_cnt_r - 4'd1;
            end
        end else begin
            pf_active_r <= pf_active_r;
        end
    end

    assign o_fetch_ack = ack_r | hit_s;
    assign o_inst_read = hit_s ? pf_buf_r : inst_r;
    assign o_fault     = fault_r;
`else
    assign hit_s       = 1'b0;
    assign o_fetch_ack = ack_r;
    assign o_inst_read = inst_r;
    assign o_fault     = fault_r;
`endif

endmodule

// File: tb/tb_zacore_imem.sv
// Directed bench for zacore_imem: three instances with WAIT_STATES 1, 3 and 0.
// The zero-wait instance also carries the next-line prefetch checks when
// ZACORE_IMEM_NEXT_PREFETCH_EN is defined.
module tb_zacore_imem;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        req   [3];
    logic [29:0] addr  [3];
    logic        we    [3];
    logic [29:0] laddr [3];
    logic [31:0] ldata [3];
    logic        ack   [3];
    logic [31:0] inst  [3];
    logic        fault [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zacore_imem #(.DEPTH(1024), .WAIT_STATES(1)) u_dut_ws1 (
        .i_clk(clk), .i_rst(rst), .i_fetch_req(req[0]), .o_fetch_ack(ack[0]),
        .i_fetch_addr(addr[0]), .o_inst_read(inst[0]), .o_fault(fault[0]),
        .i_load_we(we[0]), .i_load_addr(laddr[0]), .i_load_data(ldata[0]));

    zacore_imem #(.DEPTH(1024), .WAIT_STATES(3)) u_dut_ws3 (
        .i_clk(clk), .i_rst(rst), .i_fetch_req(req[1]), .o_fetch_ack(ack[1]),
        .i_fetch_addr(addr[1]), .o_inst_read(inst[1]), .o_fault(fault[1]),
        .i_load_we(we[1]), .i_load_addr(laddr[1]), .i_load_data(ldata[1]));

    zacore_imem #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .i_clk(clk), .i_rst(rst), .i_fetch_req(req[2]), .o_fetch_ack(ack[2]),
        .i_fetch_addr(addr[2]), .o_inst_read(inst[2]), .o_fault(fault[2]),
        .i_load_we(we[2]), .i_load_addr(laddr[2]), .i_load_data(ldata[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [29:0] a, input logic [31:0] d);
        we[idx]    = 1'b1;
        laddr[idx] = a;
        ldata[idx] = d;
        step();
        we[idx] = 1'b0;
    endtask

    // Hold a request until ack (bounded); lat counts cycles from the first request cycle.
    task automatic run_read(input int idx, input logic [29:0] a, output int lat,
                            output logic [31:0] data, output logic flt);
        lat  = -1;
        data = 32'd0;
        flt  = 1'b0;
        req[idx]  = 1'b1;
        addr[idx] = a;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack[idx]) begin
                lat  = c;
                data = inst[idx];
                flt  = fault[idx];
                break;
            end
            step();
        end
        step();
        req[idx] = 1'b0;
    endtask

    task automatic count_acks(input int idx, input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (ack[idx]) cnt++;
            step();
        end
    endtask

    initial begin
        int          lat;
        int          cnt;
        logic [31:0] data;
        logic        flt;

        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = 30'd0; we[i] = 1'b0; laddr[i] = 30'd0; ldata[i] = 32'd0;
        end

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_ack", {31'd0, ack[0]}, 32'd0);
        check("rst_inst", inst[0], 32'd0);
        check("rst_fault", {31'd0, fault[0]}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Single read, WAIT_STATES=1
        load(0, 30'd5, 32'hDEADBEEF);
        run_read(0, 30'd5, lat, data, flt);
        check("single_lat", 32'(lat), 32'd2);
        check("single_data", data, 32'hDEADBEEF);
        check("single_fault", {31'd0, flt}, 32'd0);
        @(negedge clk);
        check("single_ack_once", {31'd0, ack[0]}, 32'd0);
        step();

        // Out-of-range read
        run_read(0, 30'd1024, lat, data, flt);
        check("oor_lat", 32'(lat), 32'd2);
        check("oor_data", data, 32'h00000013);
        check("oor_fault", {31'd0, flt}, 32'd1);
        @(negedge clk);
        check("oor_fault_pulse", {31'd0, fault[0]}, 32'd0);
        step();

        // Load/read collision on the edge entering RESP
        load(0, 30'd9, 32'h11111111);
        req[0]  = 1'b1;
        addr[0] = 30'd9;
        step();
        we[0] = 1'b1; laddr[0] = 30'd9; ldata[0] = 32'h12345678;
        @(negedge clk);
        check("coll_no_early_ack", {31'd0, ack[0]}, 32'd0);
        step();
        we[0] = 1'b0;
        @(negedge clk);
        check("coll_ack", {31'd0, ack[0]}, 32'd1);
        check("coll_data", inst[0], 32'h12345678);
        step();
        req[0] = 1'b0;
        step();

        // Abort, WAIT_STATES=3
        load(1, 30'd7, 32'hCAFE0007);
        req[1]  = 1'b1;
        addr[1] = 30'd3;
        step();
        step();
        req[1] = 1'b0;
        count_acks(1, 6, cnt);
        check("abort_no_ack", 32'(cnt), 32'd0);
        run_read(1, 30'd7, lat, data, flt);
        check("abort_next_lat", 32'(lat), 32'd4);
        check("abort_next_data", data, 32'hCAFE0007);

        // Zero wait states
        load(2, 30'd20, 32'hA5A5F00F);
        run_read(2, 30'd20, lat, data, flt);
        check("ws0_lat", 32'(lat), 32'd1);
        check("ws0_data", data, 32'hA5A5F00F);

        // Reset mid-WAIT
        req[1]  = 1'b1;
        addr[1] = 30'd7;
        step();
        step();
        rst    = 1'b1;
        req[1] = 1'b0;
        #1;
        check("rstw_ack", {31'd0, ack[1]}, 32'd0);
        check("rstw_inst", inst[1], 32'd0);
        check("rstw_fault", {31'd0, fault[1]}, 32'd0);
        check("rstw_inst_other", inst[0], 32'd0);
        step();
        rst = 1'b0;
        count_acks(1, 6, cnt);
        check("rstw_no_ack", 32'(cnt), 32'd0);
        run_read(1, 30'd7, lat, data, flt);
        check("rstw_ram_lat", 32'(lat), 32'd4);
        check("rstw_ram_data", data, 32'hCAFE0007);

`ifdef ZACORE_IMEM_NEXT_PREFETCH_EN
        // Prefetch, WAIT_STATES=0
        load(2, 30'd0, 32'h00000100);
        load(2, 30'd1, 32'h00000101);
        load(2, 30'd2, 32'h00000102);
        run_read(2, 30'd0, lat, data, flt);
        check("pf_miss_lat", 32'(lat), 32'd1);
        check("pf_miss_data", data, 32'h00000100);
        step();
        step();
        run_read(2, 30'd1, lat, data, flt);
        check("pf_hit_lat", 32'(lat), 32'd0);
        check("pf_hit_data", data, 32'h00000101);
        check("pf_hit_fault", {31'd0, flt}, 32'd0);
        load(2, 30'd2, 32'h0000BEEF);
        run_read(2, 30'd2, lat, data, flt);
        check("pf_inval_lat", 32'(lat), 32'd1);
        check("pf_inval_data", data, 32'h0000BEEF);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/zacore_imem.md
# zacore_imem

Instruction-memory responder for the Zacore fetch port: the memory side of the fetch request/acknowledge handshake. It holds a word-addressed instruction RAM, inserts a configurable number of wait states, and returns one 32-bit instruction word per acknowledged request. A separate load port writes program words into the RAM. The block sits between the fetch stage and the instruction store in the SoC top level.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two, 2..2^30.
- WAIT_STATES, 1: extra cycles between request sampling and acknowledge, 0..15.
- ILLEGAL_WORD, 32'h00000013: word returned for out-of-range addresses.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_fetch_req  in  1  fetch request from the fetch stage.
- o_fetch_ack  out  1  acknowledge; o_inst_read is valid in the same cycle.
- i_fetch_addr  in  30  word address (byte address [31:2]).
- o_inst_read  out  32  instruction word.
- o_fault  out  1  one-cycle pulse, coincident with an ack for an out-of-range address.
- i_load_we  in  1  load-port write enable.
- i_load_addr  in  30  load-port word address; out-of-range writes are dropped.
- i_load_data  in  32  load-port write data.

## Operation
- Handshake: the requester holds i_fetch_req high and i_fetch_addr stable until the cycle in which o_fetch_ack=1, consumes o_inst_read at that edge, and may present a new address the following cycle. o_fetch_ack is never high while i_fetch_req is low.
- FSM states are IDLE, WAIT, and RESP.
  - IDLE: if i_fetch_req is high, latch the address. Go to RESP if WAIT_STATES==0, otherwise go to WAIT with a counter loaded to WAIT_STATES-1.
  - WAIT: decrement the counter. At 0, go to RESP. If i_fetch_req is low in any WAIT cycle, abort to IDLE with no ack.
  - RESP: o_fetch_ack=1 for exactly one cycle, then go to IDLE unconditionally.
- Read: o_inst_read is registered. It is loaded on the edge that enters RESP, from mem[latched address].
- Out-of-range reads: an address >= DEPTH returns ILLEGAL_WORD and asserts o_fault in the RESP cycle. The RAM is not accessed.
- Load/read collision: if i_load_we targets the latched address on the edge entering RESP, o_inst_read takes i_load_data (write-first forwarding). A write on any other edge simply updates the RAM.
- Reset:
  - Reset clears the FSM to IDLE, the counter to 0, o_fetch_ack to 0, o_inst_read to 0 and o_fault to 0.
  - RAM contents are not cleared.
  - Reset during WAIT or RESP drops the transaction; no ack is issued after release.

## Timing
- Miss latency: i_fetch_req is first seen high in IDLE in cycle N, and ack occurs in cycle N+1+WAIT_STATES.
- Throughput without prefetch: one word per 2+WAIT_STATES cycles, because RESP always returns to IDLE.
- o_fetch_ack and o_fault are registered FSM decodes. The exception is a prefetch hit (see Configuration).

## Configuration
ZACORE_IMEM_NEXT_PREFETCH_EN

**Defined:**
- After a RESP for address A, the block speculatively reads A+1. The addition wraps modulo 2^30, and no prefetch is started if A+1 >= DEPTH.
- The prefetch counts down WAIT_STATES+1 cycles, then loads an internal buffer and sets it valid.
- Prefetch hit: in IDLE with i_fetch_req=1, a valid buffer and i_fetch_addr equal to the prefetch address:
  - o_fetch_ack=1 combinationally in that same cycle, with o_inst_read muxed from the buffer.
  - The FSM stays in IDLE and a prefetch of the next address starts.
- Prefetch miss: any other address takes the normal path and aborts the pending prefetch.
- A load write to the prefetch address, a miss, or reset invalidates or aborts the prefetch.

**Undefined:** no speculative reads are made, and o_fetch_ack is purely registered.

## Test plan
- Single read: WAIT_STATES=1, mem[5]=32'hDEADBEEF, hold req with addr 5 from cycle 0 -> ack in cycle 2 only, o_inst_read=32'hDEADBEEF, o_fault=0.
- Abort: WAIT_STATES=3, drop req in cycle 2 -> no ack; a later request to addr 7 acks 4 cycles after it is seen, with mem[7].
- Out of range: DEPTH=1024, addr 30'd1024 -> ack with o_inst_read=32'h00000013 and o_fault=1 for one cycle.
- Collision: load write 32'h12345678 to addr 9 on the edge entering RESP for addr 9 -> o_inst_read=32'h12345678.
- Reset mid-WAIT: assert i_rst in the WAIT state -> all outputs 0 immediately, no ack after release, RAM contents intact.
- Prefetch (macro defined, WAIT_STATES=0): request addr 0, then addr 1 three cycles after the ack -> addr 1 acked in the same cycle the request is seen; a write to addr 2 before its request -> addr 2 takes the miss path and returns the new data.
